lr35902_oam_dma: RTL and testbench

//  OAM DMA engine behind I/O register FF46: a CPU write of byte H copies 160 bytes

---
 rtl/lr35902_oam_dma_pkg.sv | 28 ++
 rtl/lr35902_oam_dma_if.sv | 30 +++
 rtl/lr35902_oam_dma.sv | 157 +++++++++++++++
 tb/tb_lr35902_oam_dma.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lr35902_oam_dma_pkg.sv
// lr35902_oam_dma_pkg
//   Shared definitions for the FF46 OAM DMA engine: default transfer
//   geometry, the engine state encoding and the source-page mapping helper.
package lr35902_oam_dma_pkg;

  localparam int OAM_BYTES_DEF       = 160;
  localparam int CYCLES_PER_BYTE_DEF = 4;
  localparam int START_DELAY_DEF     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } dma_state_e;

  // Pages E0..FF alias the work-RAM echo region, so they are folded down by
  // 0x20 to reach the real RAM behind them.
  function automatic logic [7:0] dma_src_page(input logic [7:0] h);
    logic [7:0] page;
    if (h >= 8'hE0) begin
      page = h - 8'h20;
    end else begin
      page = h;
    end
    return page;
  endfunction

endpackage

// File: rtl/lr35902_oam_dma_if.sv
// lr35902_oam_dma_if
//   Bus bundle of the OAM DMA engine.
//   CPU side : din (write data), dout (FF46 readback), read, write strobes.
//   DMA read : adr_rd, rd out of the engine; data_in returned by the memory map.
//   OAM write: adr_wr, wr, data_out out of the engine.
//   active   : engine owns the OAM/VRAM/external buses.
//   master = system side (CPU + memory map), slave = DMA engine.
interface lr35902_oam_dma_if;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        read;
  logic        write;
  logic [15:0] adr_rd;
  logic        rd;
  logic [7:0]  data_in;
  logic [7:0]  adr_wr;
  logic        wr;
  logic [7:0]  data_out;
  logic        active;

  modport master (
    output din, read, write, data_in,
    input  dout, adr_rd, rd, adr_wr, wr, data_out, active
  );

  modport slave (
    input  din, read, write, data_in,
    output dout, adr_rd, rd, adr_wr, wr, data_out, active
  );
endinterface

// File: rtl/lr35902_oam_dma.sv
// lr35902_oam_dma
//   OAM DMA engine behind FF46. A CPU write of H copies OAM_BYTES bytes from
//   {page(H), 00..} into OAM 00... Each byte takes CYCLES_PER_BYTE clocks:
//   read strobe for all but the last, OAM write strobe on the last.
//   Ports: clk, reset (async, active-high), bus (lr35902_oam_dma_if.slave).
//   All bus outputs are registered.
module lr35902_oam_dma
  import lr35902_oam_dma_pkg::*;
#(
  parameter int CYCLES_PER_BYTE = CYCLES_PER_BYTE_DEF,
  parameter int START_DELAY     = START_DELAY_DEF,
  parameter int OAM_BYTES       = OAM_BYTES_DEF
) (
  input logic              clk,
  input logic              reset,
  lr35902_oam_dma_if.slave bus
);

  // One down-counter serves both the start delay and the per-byte phase.
  localparam int CNT_MAX = (CYCLES_PER_BYTE > START_DELAY) ? CYCLES_PER_BYTE : START_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_BYTE  = CNT_W'(CYCLES_PER_BYTE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       IDX_LAST  = 8'(OAM_BYTES - 1);

  dma_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       src_q, src_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       dout_q, dout_d;
  logic [15:0]      adr_rd_q, adr_rd_d;
  logic [7:0]       adr_wr_q, adr_wr_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             active_q, active_d;
  logic             xfer_d;
  logic             unused_read_s;

  // The CPU read strobe is not needed: readback is a plain register.
  assign unused_read_s = bus.read;

  // Next state, counters, source page and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    src_d   = src_q;
    data_d  = data_q;
    if (bus.write) begin
      // A write in any state (re)starts; an in-flight byte is dropped.
      state_d = ST_START;
      cnt_d   = CNT_START;
      src_d   = dma_src_page(bus.din);
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_START: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_XFER;
            idx_d   = 8'd0;
            cnt_d   = CNT_BYTE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_XFER: begin
          if (cnt_q == CNT_ZERO) begin
            // Write phase of this byte is ending.
            if (idx_q == IDX_LAST) begin
              state_d = ST_IDLE;
            end else begin
              idx_d = idx_q + 8'd1;
              cnt_d = CNT_BYTE;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
            // Last read phase: the memory map presents the byte now.
            if (cnt_q == CNT_ONE) begin
              data_d = bus.data_in;
            end else begin
              data_d = data_q;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Registered bus outputs derived from the next state.
  always_comb begin
    xfer_d = (state_d == ST_XFER);
    if (xfer_d) begin
      rd_d     = (cnt_d != CNT_ZERO);
      wr_d     = (cnt_d == CNT_ZERO);
      adr_rd_d = {src_d, idx_d};
      adr_wr_d = idx_d;
    end else begin
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      adr_rd_d = adr_rd_q;
      adr_wr_d = adr_wr_q;
    end
    // START only keeps the bus if it was already owned (restart case).
    active_d = xfer_d | ((state_d == ST_START) & active_q);
    if (bus.write) begin
      dout_d = bus.din;
    end else begin
      dout_d = dout_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      idx_q    <= 8'd0;
      src_q    <= 8'd0;
      data_q   <= 8'd0;
      dout_q   <= 8'hFF;
      adr_rd_q <= 16'd0;
      adr_wr_q <= 8'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      src_q    <= src_d;
      data_q   <= data_d;
      dout_q   <= dout_d;
      adr_rd_q <= adr_rd_d;
      adr_wr_q <= adr_wr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      active_q <= active_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.adr_rd   = adr_rd_q;
  assign bus.rd       = rd_q;
  assign bus.adr_wr   = adr_wr_q;
  assign bus.wr       = wr_q;
  assign bus.data_out = data_q;
  assign bus.active   = active_q;

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// tb_lr35902_oam_dma
//   Two engines: default timing (4 clk/byte, 4 clk start) and the fast
//   corner (2 clk/byte, 1 clk start). The source memory is a keyed function
//   of the address; expected OAM traffic is derived from the transfer rules.
module tb_lr35902_oam_dma;

  localparam int OAM_N = 160;
  localparam int CPB_A = 4;
  localparam int SD_A  = 4;
  localparam int CPB_B = 2;
  localparam int SD_B  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_t   [2];
  logic [7:0] din_t   [2];
  logic       write_t [2];
  logic [7:0] key_t   [2];

  logic [7:0]  dout_o     [2];
  logic [15:0] adr_rd_o   [2];
  logic        rd_o       [2];
  logic [7:0]  adr_wr_o   [2];
  logic        wr_o       [2];
  logic [7:0]  data_out_o [2];
  logic        active_o   [2];

  int checks = 0;
  int errors = 0;

  lr35902_oam_dma_if bus_a ();
  lr35902_oam_dma_if bus_b ();

  assign bus_a.din     = din_t[0];
  assign bus_a.write   = write_t[0];
  assign bus_a.read    = 1'b0;
  assign bus_a.data_in = bus_a.adr_rd[7:0] ^ bus_a.adr_rd[15:8] ^ key_t[0];
  assign bus_b.din     = din_t[1];
  assign bus_b.write   = write_t[1];
  assign bus_b.read    = 1'b0;
  assign bus_b.data_in = bus_b.adr_rd[7:0] ^ bus_b.adr_rd[15:8] ^ key_t[1];

  assign dout_o[0]     = bus_a.dout;
  assign adr_rd_o[0]   = bus_a.adr_rd;
  assign rd_o[0]       = bus_a.rd;
  assign adr_wr_o[0]   = bus_a.adr_wr;
  assign wr_o[0]       = bus_a.wr;
  assign data_out_o[0] = bus_a.data_out;
  assign active_o[0]   = bus_a.active;
  assign dout_o[1]     = bus_b.dout;
  assign adr_rd_o[1]   = bus_b.adr_rd;
  assign rd_o[1]       = bus_b.rd;
  assign adr_wr_o[1]   = bus_b.adr_wr;
  assign wr_o[1]       = bus_b.wr;
  assign data_out_o[1] = bus_b.data_out;
  assign active_o[1]   = bus_b.active;

  lr35902_oam_dma #(.CYCLES_PER_BYTE(CPB_A), .START_DELAY(SD_A), .OAM_BYTES(OAM_N))
    dut_a (.clk(clk), .reset(rst_t[0]), .bus(bus_a));
  lr35902_oam_dma #(.CYCLES_PER_BYTE(CPB_B), .START_DELAY(SD_B), .OAM_BYTES(OAM_N))
    dut_b (.clk(clk), .reset(rst_t[1]), .bus(bus_b));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Echo pages E0..FF read from C0..DF.
  function automatic logic [7:0] model_src(input logic [7:0] h);
    int v;
    v = int'(h);
    if (v >= 224) v = v - 32;
    return 8'(v);
  endfunction

  task automatic check_reset_vals(input int d);
    check_val("rst_dout", 32'(dout_o[d]), 32'hFF);
    check_val("rst_adr_rd", 32'(adr_rd_o[d]), 32'h0);
    check_val("rst_rd", 32'(rd_o[d]), 32'h0);
    check_val("rst_adr_wr", 32'(adr_wr_o[d]), 32'h0);
    check_val("rst_wr", 32'(wr_o[d]), 32'h0);
    check_val("rst_data_out", 32'(data_out_o[d]), 32'h0);
    check_val("rst_active", 32'(active_o[d]), 32'h0);
  endtask

  // Called at a negedge; write is sampled on the following posedge.
  task automatic cpu_write(input int d, input logic [7:0] h);
    din_t[d]   = h;
    write_t[d] = 1'b1;
    @(negedge clk);
    write_t[d] = 1'b0;
    check_val("dout", 32'(dout_o[d]), 32'(h));
  endtask

  // Follows one transfer, starting at the negedge after the write edge.
  // mode 0: run to completion; 1: restart with h_next on first read of
  // stop_idx; 2: restart with h_next on the final OAM write; 3: reset on the
  // second read phase of stop_idx.
  task automatic run_pass(input int d, input logic [7:0] h, input bit restarted,
                          input int mode, input int stop_idx, input logic [7:0] h_next);
    logic [7:0] src;
    int cpb, sd, k, exp_idx, wr_cnt, act_cnt, rd_run;
    bit done;
    src = model_src(h);
    cpb = (d == 0) ? CPB_A : CPB_B;
    sd  = (d == 0) ? SD_A : SD_B;
    k = 0; exp_idx = 0; wr_cnt = 0; act_cnt = 0; rd_run = 0; done = 1'b0;
    while (!done && k < 4000) begin
      if (k == sd - 1) begin
        check_val("start_rd", 32'(rd_o[d]), 32'h0);
        check_val("start_wr", 32'(wr_o[d]), 32'h0);
        check_val("start_active", 32'(active_o[d]), 32'(restarted));
      end
      if (k == sd) begin
        check_val("first_rd", 32'(rd_o[d]), 32'h1);
        check_val("first_adr", 32'(adr_rd_o[d]), 32'({src, 8'h00}));
      end
      if (k >= sd) begin
        if (active_o[d]) begin
          act_cnt++;
          check_val("rd_xor_wr", 32'(rd_o[d] ^ wr_o[d]), 32'h1);
          if (rd_o[d]) begin
            check_val("adr_rd", 32'(adr_rd_o[d]), 32'({src, 8'(exp_idx)}));
            rd_run++;
            if (mode == 1 && rd_run == 1 && exp_idx == stop_idx) begin
              check_val("pre_restart_wr", 32'(wr_cnt), 32'(stop_idx));
              cpu_write(d, h_next);
              return;
            end
            if (mode == 3 && rd_run == 2 && exp_idx == stop_idx) begin
              #1 rst_t[d] = 1'b1;
              #1 check_reset_vals(d);
              @(negedge clk);
              rst_t[d] = 1'b0;
              for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                check_val("idle_after_rst", 32'({active_o[d], rd_o[d], wr_o[d]}), 32'h0);
              end
              return;
            end
          end
          if (wr_o[d]) begin
            check_val("adr_wr", 32'(adr_wr_o[d]), 32'(exp_idx));
            check_val("data_out", 32'(data_out_o[d]), 32'(8'(exp_idx) ^ src ^ key_t[d]));
            check_val("rd_phases", 32'(rd_run), 32'(cpb - 1));
            wr_cnt++;
            rd_run = 0;
            if (mode == 2 && exp_idx == OAM_N - 1) begin
              check_val("final_wr_count", 32'(wr_cnt), 32'(OAM_N));
              check_val("final_act_cycles", 32'(act_cnt), 32'(OAM_N * cpb));
              cpu_write(d, h_next);
              return;
            end
            exp_idx++;
          end
        end else begin
          check_val("end_rd", 32'(rd_o[d]), 32'h0);
          check_val("end_wr", 32'(wr_o[d]), 32'h0);
          check_val("wr_count", 32'(wr_cnt), 32'(OAM_N));
          check_val("act_cycles", 32'(act_cnt), 32'(OAM_N * cpb));
          done = 1'b1;
        end
      end
      if (!done) begin
        @(negedge clk);
        k++;
      end
    end
    if (!done) check_val("timeout", 32'h0, 32'h1);
  endtask

  initial begin
    logic [7:0] h1, h2;
    for (int d = 0; d < 2; d++) begin
      rst_t[d]   = 1'b1;
      din_t[d]   = 8'h00;
      write_t[d] = 1'b0;
      key_t[d]   = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    rst_t[0] = 1'b0;
    rst_t[1] = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals(0);

    // Basic page and echo-region page.
    cpu_write(0, 8'hC1);
    run_pass(0, 8'hC1, 1'b0, 0, 0, 8'h00);
    key_t[0] = 8'($urandom);
    cpu_write(0, 8'hFE);
    run_pass(0, 8'hFE, 1'b0, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    check_val("dout_hold", 32'(dout_o[0]), 32'hFE);

    // Restart mid-transfer.
    cpu_write(0, 8'h80);
    run_pass(0, 8'h80, 1'b0, 1, 32, 8'h90);
    run_pass(0, 8'h90, 1'b1, 0, 0, 8'h00);

    // Reset mid-transfer, then a normal transfer afterwards.
    h1 = 8'($urandom);
    cpu_write(0, h1);
    run_pass(0, h1, 1'b0, 3, 80, 8'h00);
    h1 = 8'($urandom);
    cpu_write(0, h1);
    run_pass(0, h1, 1'b0, 0, 0, 8'h00);

    // Write coinciding with the final OAM write.
    h1 = 8'($urandom);
    h2 = 8'($urandom);
    cpu_write(0, h1);
    run_pass(0, h1, 1'b0, 2, 0, h2);
    run_pass(0, h2, 1'b1, 0, 0, 8'h00);

    // Random pages with a random restart point.
    for (int n = 0; n < 2; n++) begin
      key_t[0] = 8'($urandom);
      h1 = 8'($urandom);
      h2 = 8'($urandom);
      cpu_write(0, h1);
      run_pass(0, h1, 1'b0, 1, int'($urandom_range(0, OAM_N - 1)), h2);
      run_pass(0, h2, 1'b1, 0, 0, 8'h00);
    end

    // Fast corner: 2 clk per byte, 1 clk start delay.
    check_reset_vals(1);
    cpu_write(1, 8'hE0);
    run_pass(1, 8'hE0, 1'b0, 0, 0, 8'h00);
    key_t[1] = 8'($urandom);
    h1 = 8'($urandom);
    cpu_write(1, h1);
    run_pass(1, h1, 1'b0, 0, 0, 8'h00);
    h1 = 8'($urandom);
    h2 = 8'($urandom);
    cpu_write(1, h1);
    run_pass(1, h1, 1'b0, 1, int'($urandom_range(0, OAM_N - 1)), h2);
    run_pass(1, h2, 1'b1, 0, 0, 8'h00);
    h1 = 8'($urandom);
    h2 = 8'($urandom);
    cpu_write(1, h1);
    run_pass(1, h1, 1'b0, 2, 0, h2);
    run_pass(1, h2, 1'b1, 0, 0, 8'h00);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
